// File: rtl/chain_meas_ctrl.sv
// Delay-chain latency measurement controller.
// Launches a toggle on one chain and counts clk cycles until it returns.
module chain_meas_ctrl #(
  parameter int NCH     = 8,
  parameter int CW      = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [2:0]     chan_sel,
  output logic [NCH-1:0] chain_din,
  input  logic [NCH-1:0] chain_dout,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  result,
  output logic [2:0]     result_ch,
  output logic           timed_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  state_e         state_q, state_d;
  logic [NCH-1:0] sync1_q, sdout_q;
  logic [NCH-1:0] din_q, din_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  res_q, res_d;
  logic [2:0]     sel_q, sel_d;
  logic [2:0]     rch_q, rch_d;
  logic           to_q, to_d;
  logic           match;

  // Selected chain has settled to the level we are driving.
  assign match = (sdout_q[sel_q] == din_q[sel_q]);

  // Two-flop synchronizer on every chain output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sdout_q <= '0;
    end else begin
      sync1_q <= chain_dout;
      sdout_q <= sync1_q;
    end
  end

  // State, launch levels, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      din_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      rch_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      rch_q   <= rch_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; abort beats match, match beats timeout.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sel_d   = sel_q;
    rch_d   = rch_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = chan_sel;
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_LAUNCH;
        end else if (cnt_q == TO_C) begin
          res_d   = '0;
          to_d    = 1'b1;
          rch_d   = sel_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          din_d[sel_q] = ~din_q[sel_q];
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          res_d   = cnt_q;
          to_d    = 1'b0;
          rch_d   = sel_q;
          state_d = S_DONE;
        end else if (cnt_q == TO_C) begin
          res_d   = TO_C;
          to_d    = 1'b1;
          rch_d   = sel_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign chain_din = din_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = res_q;
  assign result_ch = rch_q;
  assign timed_out = to_q;

endmodule

// File: tb/tb_chain_meas_ctrl.sv
// Scoreboard bench for chain_meas_ctrl.
// Two instances: long timeout (A) and TIMEOUT=50 (B).
module tb_chain_meas_ctrl;

  typedef struct {
    logic [11:0] res;
    logic [2:0]  ch;
    logic        to;
  } exp_t;

  localparam int DLY_A [8] = '{0, 100, 7, 100, 1, 100, 0, 0};
  localparam int DLY_B [8] = '{0, 0, 0, 0, 0, 0, 48, 0};

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic abort_a = 1'b0, abort_b = 1'b0;
  logic [2:0] sel_a = '0, sel_b = '0;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [11:0] res_a, res_b;
  logic [2:0] rch_a, rch_b;
  logic to_a, to_b;

  logic [255:0] sh_a [8];
  logic [255:0] sh_b [8];

  exp_t q_a[$];
  exp_t q_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chain_meas_ctrl #(.NCH(8), .CW(12), .TIMEOUT(200)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .abort(abort_a),
    .chan_sel(sel_a), .chain_din(din_a), .chain_dout(dout_a),
    .busy(busy_a), .done(done_a), .result(res_a),
    .result_ch(rch_a), .timed_out(to_a)
  );

  chain_meas_ctrl #(.NCH(8), .CW(12), .TIMEOUT(50)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .abort(abort_b),
    .chan_sel(sel_b), .chain_din(din_b), .chain_dout(dout_b),
    .busy(busy_b), .done(done_b), .result(res_b),
    .result_ch(rch_b), .timed_out(to_b)
  );

  // Delay-line models: tap D-1 follows din D edges later.
  always @(posedge clk or negedge rst_a) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_a) sh_a[i] <= '0;
      else sh_a[i] <= {sh_a[i][254:0], din_a[i]};
    end
  end

  always @(posedge clk or negedge rst_b) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_b) sh_b[i] <= '0;
      else sh_b[i] <= {sh_b[i][254:0], din_b[i]};
    end
  end

  always_comb begin
    dout_a = '0;
    dout_b = '0;
    for (int i = 0; i < 8; i++) begin
      if (DLY_A[i] > 0) dout_a[i] = sh_a[i][DLY_A[i]-1];
      if (DLY_B[i] > 0) dout_b[i] = sh_b[i][DLY_B[i]-1];
    end
  end

  // Monitor: every done pulse pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL done_a unexpected: res=%0d ch=%0d to=%0b",
                 res_a, rch_a, to_a);
      end else begin
        e = q_a.pop_front();
        if ({res_a, rch_a, to_a} !== {e.res, e.ch, e.to}) begin
          n_bad++;
          $display("FAIL done_a: got res=%0d ch=%0d to=%0b want res=%0d ch=%0d to=%0b",
                   res_a, rch_a, to_a, e.res, e.ch, e.to);
        end
      end
    end
    if (done_b === 1'b1) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL done_b unexpected: res=%0d ch=%0d to=%0b",
                 res_b, rch_b, to_b);
      end else begin
        e = q_b.pop_front();
        if ({res_b, rch_b, to_b} !== {e.res, e.ch, e.to}) begin
          n_bad++;
          $display("FAIL done_b: got res=%0d ch=%0d to=%0b want res=%0d ch=%0d to=%0b",
                   res_b, rch_b, to_b, e.res, e.ch, e.to);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input bit b);
    int k = 0;
    while ((b ? busy_b : busy_a) !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle dut%s: busy=1 want 0", b ? "B" : "A");
    end
  endtask

  task automatic measure(input bit b, input logic [2:0] ch,
                         input logic [11:0] r, input logic t);
    exp_t e;
    e.res = r;
    e.ch  = ch;
    e.to  = t;
    if (b) q_b.push_back(e);
    else q_a.push_back(e);
    @(negedge clk);
    if (b) begin start_b = 1'b1; sel_b = ch; end
    else begin start_a = 1'b1; sel_a = ch; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_idle(b);
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, " busy"}, 32'(busy_a), 0);
    chk({nm, " done"}, 32'(done_a), 0);
    chk({nm, " result"}, 32'(res_a), 0);
    chk({nm, " result_ch"}, 32'(rch_a), 0);
    chk({nm, " timed_out"}, 32'(to_a), 0);
    chk({nm, " chain_din"}, 32'(din_a), 0);
  endtask

  initial begin
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk_zero_a("rstA");
    chk("rstB chain_din", 32'(din_b), 0);
    chk("rstB busy", 32'(busy_b), 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    measure(0, 3'd3, 12'd102, 1'b0);
    chk("ch3 rise din", 32'(din_a[3]), 1);
    measure(0, 3'd3, 12'd102, 1'b0);
    chk("ch3 fall din", 32'(din_a[3]), 0);
    measure(0, 3'd4, 12'd3, 1'b0);
    chk("ch4 din", 32'(din_a), 32'h10);

    @(negedge clk);
    start_a = 1'b1;
    sel_a = 3'd5;
    @(negedge clk);
    start_a = 1'b0;
    repeat (28) @(negedge clk);
    start_a = 1'b1;
    sel_a = 3'd2;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort busy", 32'(busy_a), 0);
    chk("abort result", 32'(res_a), 3);
    chk("abort result_ch", 32'(rch_a), 4);
    chk("abort timed_out", 32'(to_a), 0);
    chk("abort din", 32'(din_a), 32'h30);
    repeat (150) @(negedge clk);
    chk("abort stays idle", 32'(busy_a), 0);

    @(negedge clk);
    start_a = 1'b1;
    sel_a = 3'd1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("ch1 busy in wait", 32'(busy_a), 1);
    rst_a = 1'b0;
    #1;
    chk_zero_a("midrst");
    @(negedge clk);
    rst_a = 1'b1;
    measure(0, 3'd2, 12'd9, 1'b0);
    chk("ch2 din", 32'(din_a), 32'h04);

    measure(1, 3'd0, 12'd50, 1'b1);
    chk("ch0 timeout din", 32'(din_b[0]), 1);
    measure(1, 3'd0, 12'd0, 1'b1);
    chk("ch0 arm timeout din", 32'(din_b[0]), 1);
    measure(1, 3'd6, 12'd50, 1'b0);
    chk("ch6 din", 32'(din_b), 32'h41);

    repeat (5) @(negedge clk);
    chk("queue A drained", 32'(q_a.size()), 0);
    chk("queue B drained", 32'(q_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chain_meas_ctrl.md
CHAIN_MEAS_CTRL -- requirements
Module: chain_meas_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of delay chains controlled.
REQ-002 Parameter CW, default 12, width of the latency counter and result.
REQ-003 Parameter TIMEOUT, default 4095, maximum count before abandoning a measurement; SHALL satisfy 1 <= TIMEOUT <= 2^CW-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 abort  input  1  cancel the measurement in progress.
REQ-008 chan_sel  input  3  chain index to measure; sampled with start.
REQ-009 chain_din  output  NCH  registered launch levels, one per chain.
REQ-010 chain_dout  input  NCH  chain outputs; treated as asynchronous.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a measurement completes or times out.
REQ-013 result  output  CW  measured latency in clk cycles; holds until the next done.
REQ-014 result_ch  output  3  chain index belonging to result.
REQ-015 timed_out  output  1  qualifies result; holds until the next done.

Function
REQ-016 Each chain_dout bit SHALL pass through a 2-flop synchronizer; all comparisons use the second flop (sdout).
REQ-017 The FSM SHALL have exactly the states IDLE, ARM, LAUNCH, WAIT, DONE.
REQ-018 IDLE: start=1 SHALL latch chan_sel into sel, clear the counter, and enter ARM; start in any other state SHALL be ignored.
REQ-019 ARM: if sdout[sel]==chain_din[sel] -> LAUNCH. Otherwise the counter increments; when counter==TIMEOUT -> DONE with timed_out=1 and result=0.
REQ-020 LAUNCH: chain_din[sel] SHALL toggle on the exit edge (E0), the counter clears to 0, and the FSM enters WAIT; other chain_din bits SHALL be unchanged.
REQ-021 WAIT: on each edge, if sdout[sel]==chain_din[sel] -> capture result=counter, timed_out=0 -> DONE. Else if counter==TIMEOUT -> capture result=TIMEOUT, timed_out=1 -> DONE. Else the counter increments.
REQ-022 A match SHALL take priority over timeout in the same cycle.
REQ-023 For a chain whose dout follows din D edges after E0, result SHALL equal D+2.
REQ-024 DONE: done=1 for exactly this one cycle, result_ch=sel, then -> IDLE; start during DONE SHALL be ignored.
REQ-025 The counter SHALL never wrap; it is bounded by TIMEOUT.
REQ-026 abort=1 in ARM, LAUNCH, or WAIT SHALL return the FSM to IDLE on the next edge.
REQ-027 On abort: no done pulse; result, result_ch, and timed_out unchanged; chain_din keeps its current value (a toggle already made is not undone).
REQ-028 abort SHALL have priority over match and timeout; abort in IDLE or DONE has no effect.
REQ-029 A chain_din level SHALL be inverted only by LAUNCH for that chain, so successive measurements alternate rising and falling launches.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE; chain_din=0; sync flops=0; counter=0; busy=0; done=0; result=0; result_ch=0; timed_out=0.
REQ-031 Reset asserted mid-measurement SHALL discard the measurement with no done pulse.
REQ-032 The first start after reset SHALL proceed normally.

Verification
REQ-033 Bench models chain 3 as a 100-register delay; start with chan_sel=3 -> chain_din[3] rises; one done pulse; result=102, result_ch=3, timed_out=0. Repeat -> chain_din[3] falls, result=102.
REQ-034 Chain 0 dout tied to 0, TIMEOUT=50; measure -> done with timed_out=1, result=50, chain_din[0]=1.
REQ-035 Then measure chain 0 again -> ARM waits 50 cycles -> done with timed_out=1, result=0, chain_din[0] unchanged.
REQ-036 Chain 5 delay 100; abort 30 cycles after start -> IDLE next cycle; no done; previous result kept; chain_din[5]=1. Start issued while busy -> ignored.
REQ-037 Reset pulse during WAIT -> all outputs 0 at once; a fresh measurement of chain 2 (delay 7) -> result=9.
REQ-038 Chain 6 delay set so the match lands exactly at counter==TIMEOUT -> timed_out=0, result=TIMEOUT.
